view_pixel_pipeline: RTL and testbench
======================================

Name: view_pixel_pipeline

Overview:
- Parametrised successor to the renderer's fetch and cursor path.
- Converts VGA raster coordinates into board-cell reads against the packed board memory, with selectable zoom, toroidal view wrap, per-frame config latching, an optional grid overlay and a cursor box.
- Emits a colour pixel plus delayed sync/blank, all aligned to a fixed pipeline latency.
- Sits between the xvga timing generator and the VGA output pins; reads through the board memory's read port.

Parameters:
- WORD_SIZE, 16, cells per memory word; power of two.
- LOG_BOARD_SIZE, 8, board is 2^LOG_BOARD_SIZE cells square.
- LOG_WORD_SIZE, 4, log2(WORD_SIZE).
- MEM_LATENCY, 2, cycles from addr_r_out registered to data_r_in valid; must be >= 1.
- SCREEN_W, 1024, visible pixels per line.
- SCREEN_H, 768, visible lines.
- ALIVE_COLOR, 12'hFFF, colour of a live cell.
- DEAD_COLOR, 12'h000, colour of a dead cell.
- GRID_COLOR, 12'h333, colour of grid lines.
- CURSOR_COLOR, 12'hF00, colour of the cursor border.

Ports:
- clk_in  in  1  pixel clock.
- rst_in  in  1  reset: synchronous, active-low.
- hcount_in  in  11  raster x from xvga.
- vcount_in  in  10  raster y from xvga.
- hsync_in, vsync_in  in  1 each  active-low syncs from xvga.
- blank_in  in  1  blank from xvga.
- view_x_in, view_y_in  in  LOG_BOARD_SIZE  board cell at screen top-left.
- cursor_x_in, cursor_y_in  in  LOG_BOARD_SIZE  cursor cell, board coordinates.
- zoom_in  in  2  cell size = 2^zoom_in pixels.
- grid_en_in  in  1  enable grid overlay.
- data_r_in  in  WORD_SIZE  memory read data.
- addr_r_out  out  2*LOG_BOARD_SIZE-LOG_WORD_SIZE  memory read address.
- pix_out  out  12  RGB444 pixel.
- hsync_out, vsync_out, blank_out  out  1 each  syncs and blank delayed by L.
- frame_done_out  out  1  one-cycle pulse at end of visible frame.

Behaviour:
- Latency L = MEM_LATENCY+2 cycles, input raster to pix_out. hsync, vsync, blank and all per-pixel side data pass through a matching L-deep shift pipeline.
- Shadow config: view_x/y, cursor_x/y, zoom and grid_en are captured in the cycle where hcount_in==0 && vcount_in==0. Stage 0 uses only the shadow copies, so mid-frame input changes take effect on the next frame.
- Stage 0 (combinational into reg):
  - cx = (view_x + (hcount_in >> zoom)) mod 2^LOG_BOARD_SIZE; cy likewise with vcount_in.
  - Addition truncates to LOG_BOARD_SIZE bits (toroidal wrap; screen may tile the board).
  - ox = hcount_in & (2^zoom-1); oy likewise.
- Stage 1: addr_r_out <= {cy, cx[LOG_BOARD_SIZE-1:LOG_WORD_SIZE]}. Bit index cx[LOG_WORD_SIZE-1:0], ox, oy, cursor-hit and edge flags are registered alongside.
- Data alignment: data_r_in is sampled MEM_LATENCY cycles after stage 1; alive = data_r_in[bit index], LSB = leftmost cell.
- Cursor hit: (cx,cy)==(cursor_x,cursor_y) and (zoom==0 or ox==0 or ox==2^zoom-1 or oy==0 or oy==2^zoom-1).
- Grid hit: grid_en && zoom>=2 && (ox==0 || oy==0). Grid is ignored for zoom<2.
- Output priority, registered at the final stage: blank → 12'h000; else cursor → CURSOR_COLOR; else alive → ALIVE_COLOR; else grid → GRID_COLOR; else DEAD_COLOR.
- addr_r_out is issued every cycle, including during blanking; the memory read port is exclusively owned.
- frame_done_out: asserted for exactly one cycle when the pixel (SCREEN_W-1, SCREEN_H-1) appears at the output, i.e. L cycles after it enters.
- Reset (rst_in==0 at a clock edge):
  - Outputs: pix_out=0, addr_r_out=0, hsync_out=1, vsync_out=1, blank_out=1, frame_done_out=0.
  - All pipeline stages cleared to blank/inactive-sync.
  - Shadows cleared: view=0, cursor=0, zoom=0, grid_en=0.
- Reset mid-frame: output stays blank until live data has flushed L cycles after release. Shadows remain 0 until the next frame-start capture. No frame_done_out for the interrupted frame unless its last pixel passes after release.
- Simultaneous frame-start capture and reset: reset wins.

Test Plan:
- Defaults, view=(0,0), zoom=0, memory word 0 = 16'h0001, all other words 0 → pixel (0,0) is 12'hFFF at cycle L=4 after hcount=vcount=0; pixel (1,0) is 12'h000; addr_r_out=0 one cycle after raster (0,0).
- zoom=2, view=(254,0), board cell (1,0) alive → screen pixels x=12..15 on line 0 are ALIVE; x=8..11 are dead; cx wraps 255→0→1.
- zoom=3, grid_en=1, cursor=(2,1), view=(0,0) → pixels (16..23,8) and (16,8..15) are 12'hF00. Pixel (32,0) is 12'h333. Pixel (19,11) is the dead colour.
- Change view_x from 0 to 5 at raster (100,100) → the remainder of the frame still uses view_x=0; the next frame's pixel (0,0) addresses cell 5, with addr_r_out low bits = 0 and bit index 5.
- Blank asserted with a live cell under the raster → pix_out=0; hsync_out/vsync_out equal the inputs delayed exactly 4 cycles.
- Assert rst_in=0 for 3 cycles mid-line → outputs hold reset values during reset and blank_out=1 for 4 cycles after release. frame_done_out pulses exactly once per completed frame thereafter (4 cycles after raster (1023,767)).

Source files
------------

// File: rtl/view_pixel_pipeline_if.sv
// Board memory read port shared by the pixel pipeline and the board RAM.
// The pipeline drives the address; the RAM returns one word per read.
interface view_pixel_pipeline_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic [AW-1:0] addr_r_out;
  logic [DW-1:0] data_r_in;

  modport master (
    output addr_r_out,
    input  data_r_in
  );

  modport slave (
    input  addr_r_out,
    output data_r_in
  );
endinterface

// File: rtl/view_pixel_pipeline.sv
// Raster-to-board-cell renderer: zoom, toroidal view, grid and cursor
// overlay, with sync/blank carried through a fixed-latency pipeline.
module view_pixel_pipeline #(
  parameter int          WORD_SIZE      = 16,
  parameter int          LOG_BOARD_SIZE = 8,
  parameter int          LOG_WORD_SIZE  = 4,
  parameter int          MEM_LATENCY    = 2,
  parameter int          SCREEN_W       = 1024,
  parameter int          SCREEN_H       = 768,
  parameter logic [11:0] ALIVE_COLOR    = 12'hFFF,
  parameter logic [11:0] DEAD_COLOR     = 12'h000,
  parameter logic [11:0] GRID_COLOR     = 12'h333,
  parameter logic [11:0] CURSOR_COLOR   = 12'hF00
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      blank_in,
  input  logic [LOG_BOARD_SIZE-1:0] view_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] view_y_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
  input  logic [1:0]                zoom_in,
  input  logic                      grid_en_in,
  view_pixel_pipeline_if.master     mem,
  output logic [11:0]               pix_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      blank_out,
  output logic                      frame_done_out
);
  localparam int LB = LOG_BOARD_SIZE;
  localparam int LW = LOG_WORD_SIZE;
  localparam int ML = MEM_LATENCY;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          bl;
    logic          last;
    logic          cur;
    logic          grid;
    logic [LW-1:0] idx;
  } side_t;

  localparam side_t IDLE = '{
    hs: 1'b1, vs: 1'b1, bl: 1'b1,
    last: 1'b0, cur: 1'b0, grid: 1'b0,
    idx: '0
  };

  logic [LB-1:0] sh_vx, sh_vy;
  logic [LB-1:0] sh_cx, sh_cy;
  logic [1:0]    sh_zoom;
  logic          sh_grid;

  logic          start;
  logic [LB-1:0] vx, vy;
  logic [LB-1:0] cur_x, cur_y;
  logic [1:0]    zoom;
  logic          grid_en;
  logic [LB-1:0] cx, cy;
  logic [2:0]    mask, ox, oy;
  logic          on_edge;
  side_t         s0;
  side_t         sp [ML+1];
  side_t         t;
  logic          alive;

  // The frame-start pixel already sees the config it is about to latch.
  always_comb begin
    start   = (hcount_in == '0) && (vcount_in == '0);
    vx      = start ? view_x_in   : sh_vx;
    vy      = start ? view_y_in   : sh_vy;
    cur_x   = start ? cursor_x_in : sh_cx;
    cur_y   = start ? cursor_y_in : sh_cy;
    zoom    = start ? zoom_in     : sh_zoom;
    grid_en = start ? grid_en_in  : sh_grid;

    cx   = vx + LB'(hcount_in >> zoom);
    cy   = vy + LB'(vcount_in >> zoom);
    mask = 3'((4'd1 << zoom) - 4'd1);
    ox   = hcount_in[2:0] & mask;
    oy   = vcount_in[2:0] & mask;

    on_edge = (ox == '0) || (ox == mask) ||
              (oy == '0) || (oy == mask);

    s0.hs   = hsync_in;
    s0.vs   = vsync_in;
    s0.bl   = blank_in;
    s0.last = (hcount_in == 11'(SCREEN_W - 1)) &&
              (vcount_in == 10'(SCREEN_H - 1));
    s0.cur  = (cx == cur_x) && (cy == cur_y) && on_edge;
    s0.grid = grid_en && (zoom >= 2'd2) &&
              ((ox == '0) || (oy == '0));
    s0.idx  = cx[LW-1:0];

    t     = sp[ML];
    alive = mem.data_r_in[t.idx];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sh_vx          <= '0;
      sh_vy          <= '0;
      sh_cx          <= '0;
      sh_cy          <= '0;
      sh_zoom        <= '0;
      sh_grid        <= 1'b0;
      mem.addr_r_out <= '0;
      for (int k = 0; k <= ML; k++) sp[k] <= IDLE;
      pix_out        <= '0;
      hsync_out      <= 1'b1;
      vsync_out      <= 1'b1;
      blank_out      <= 1'b1;
      frame_done_out <= 1'b0;
    end else begin
      if (start) begin
        sh_vx   <= view_x_in;
        sh_vy   <= view_y_in;
        sh_cx   <= cursor_x_in;
        sh_cy   <= cursor_y_in;
        sh_zoom <= zoom_in;
        sh_grid <= grid_en_in;
      end
      mem.addr_r_out <= {cy, cx[LB-1:LW]};
      sp[0] <= s0;
      for (int k = 1; k <= ML; k++) sp[k] <= sp[k-1];
      hsync_out      <= t.hs;
      vsync_out      <= t.vs;
      blank_out      <= t.bl;
      frame_done_out <= t.last;
      if (t.bl)
        pix_out <= 12'h000;
      else if (t.cur)
        pix_out <= CURSOR_COLOR;
      else if (alive)
        pix_out <= ALIVE_COLOR;
      else if (t.grid)
        pix_out <= GRID_COLOR;
      else
        pix_out <= DEAD_COLOR;
    end
  end
endmodule

// File: tb/tb_view_pixel_pipeline.sv
// Scoreboard bench for view_pixel_pipeline: directed raster vectors,
// board RAM model with two-cycle read latency, decoupled output monitor.
module tb_view_pixel_pipeline;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount = 11'd500;
  logic [9:0]  vcount = 10'd500;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        blank = 1'b1;
  logic [7:0]  vx = '0, vy = '0;
  logic [7:0]  cux = 8'd100, cuy = 8'd100;
  logic [1:0]  zoom = '0;
  logic        grid_en = 1'b0;
  logic [11:0] pix;
  logic        hs_o, vs_o, bl_o, fd_o;

  logic [15:0] ram [0:4095];
  logic [15:0] m1, m2;

  view_pixel_pipeline_if #(.AW(12), .DW(16)) mif ();

  view_pixel_pipeline dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .hsync_in      (hsync),
    .vsync_in      (vsync),
    .blank_in      (blank),
    .view_x_in     (vx),
    .view_y_in     (vy),
    .cursor_x_in   (cux),
    .cursor_y_in   (cuy),
    .zoom_in       (zoom),
    .grid_en_in    (grid_en),
    .mem           (mif),
    .pix_out       (pix),
    .hsync_out     (hs_o),
    .vsync_out     (vs_o),
    .blank_out     (bl_o),
    .frame_done_out(fd_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m1 <= ram[mif.addr_r_out];
    m2 <= m1;
  end
  assign mif.data_r_in = m2;

  typedef struct {
    int          oedge;
    logic [15:0] val;
    int          tag;
  } exp_t;

  exp_t q[$];
  exp_t aq[$];
  int   n = 0;
  int   tag = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic push_out(input int oe, input logic [11:0] px,
                          input bit hs, input bit vs,
                          input bit bl, input bit fd);
    exp_t e;
    e.oedge = oe;
    e.val   = {px, hs, vs, bl, fd};
    e.tag   = tag;
    q.push_back(e);
  endtask

  task automatic push_addr(input int oe, input int a);
    exp_t e;
    e.oedge = oe;
    e.val   = 16'(a);
    e.tag   = tag;
    aq.push_back(e);
  endtask

  task automatic drive(input int h, input int v, input bit hs,
                       input bit vs, input bit bl,
                       input logic [11:0] px, input bit chk,
                       input bit achk, input int a);
    @(negedge clk);
    hcount = 11'(h);
    vcount = 10'(v);
    hsync  = hs;
    vsync  = vs;
    blank  = bl;
    tag++;
    if (chk) push_out(n + L, px, hs, vs, bl, (h == 1023 && v == 767));
    if (achk) push_addr(n + 1, a);
  endtask

  task automatic pxl(input int h, input int v, input logic [11:0] px);
    drive(h, v, 1'b1, 1'b1, 1'b0, px, 1'b1, 1'b0, 0);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      hcount = 11'd500;
      vcount = 10'd500;
      hsync  = 1'b1;
      vsync  = 1'b1;
      blank  = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] got;
    forever begin
      @(posedge clk);
      n++;
      #1;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].oedge == n) begin
          got = {pix, hs_o, vs_o, bl_o, fd_o};
          checks++;
          if (got !== q[i].val) begin
            failures++;
            $display("FAIL out vec%0d edge%0d got=%h exp=%h (pix,hs,vs,bl,fd)",
                     q[i].tag, n, got, q[i].val);
          end
          q.delete(i);
        end
      end
      for (int i = aq.size() - 1; i >= 0; i--) begin
        if (aq[i].oedge == n) begin
          got = 16'(mif.addr_r_out);
          checks++;
          if (got !== aq[i].val) begin
            failures++;
            $display("FAIL addr vec%0d edge%0d got=%0d exp=%0d",
                     aq[i].tag, n, got, aq[i].val);
          end
          aq.delete(i);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
    ram[0] = 16'h0001;

    repeat (3) begin
      @(negedge clk);
      tag++;
      push_out(n + 1, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0);
      push_addr(n + 1, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(6);

    // zoom 0, cell 0 alive
    drive(0, 0, 1, 1, 0, 12'hFFF, 1, 1, 0);
    pxl(1, 0, 12'h000);
    drive(2, 5, 1, 1, 0, 12'h000, 1, 1, 80);
    idle(6);

    // zoom 2 with horizontal wrap 254,255,0,1
    ram[0] = 16'h0002;
    zoom = 2'd2;
    vx = 8'd254;
    drive(0, 0, 1, 1, 0, 12'h000, 1, 1, 15);
    pxl(4, 0, 12'h000);
    pxl(8, 0, 12'h000);
    pxl(11, 0, 12'h000);
    pxl(12, 0, 12'hFFF);
    pxl(15, 0, 12'hFFF);
    pxl(16, 0, 12'h000);
    idle(6);

    // zoom 3 with grid and cursor at (2,1); cell (5,1) alive
    ram[0]  = 16'h0000;
    ram[16] = 16'h0020;
    zoom = 2'd3;
    vx = 8'd0;
    grid_en = 1'b1;
    cux = 8'd2;
    cuy = 8'd1;
    pxl(0, 0, 12'h333);
    pxl(16, 8, 12'hF00);
    pxl(23, 8, 12'hF00);
    pxl(20, 8, 12'hF00);
    pxl(16, 15, 12'hF00);
    pxl(23, 15, 12'hF00);
    pxl(19, 11, 12'h000);
    pxl(32, 0, 12'h333);
    pxl(33, 1, 12'h000);
    pxl(24, 8, 12'h333);
    pxl(40, 8, 12'hFFF);
    pxl(42, 10, 12'hFFF);
    drive(42, 10, 1, 1, 1, 12'h000, 1, 0, 0);
    idle(6);

    // mid-frame view change waits for next frame
    ram[16] = 16'h0000;
    ram[0]  = 16'h0020;
    zoom = 2'd0;
    grid_en = 1'b0;
    cux = 8'd200;
    cuy = 8'd200;
    drive(0, 0, 1, 1, 0, 12'h000, 1, 1, 0);
    idle(1);
    vx = 8'd5;
    drive(100, 100, 1, 1, 0, 12'h000, 1, 1, 1606);
    pxl(5, 0, 12'hFFF);
    pxl(6, 0, 12'h000);
    drive(0, 0, 1, 1, 0, 12'hFFF, 1, 1, 0);
    pxl(1, 0, 12'h000);

    // blank and sync pass-through
    drive(0, 0, 0, 0, 1, 12'h000, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 12'h000, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 12'hFFF, 1, 0, 0);
    drive(2, 0, 0, 0, 1, 12'h000, 1, 0, 0);
    idle(6);

    // reset mid-line, with a frame-start raster during reset
    ram[0] = 16'h0008;
    pxl(10, 20, 12'h000);
    drive(11, 20, 1, 1, 0, 12'h000, 0, 0, 0);
    drive(12, 20, 1, 1, 0, 12'h000, 0, 0, 0);
    drive(13, 20, 1, 1, 0, 12'h000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0;
      hcount = (i == 1) ? 11'd0 : 11'(14 + i);
      vcount = (i == 1) ? 10'd0 : 10'd20;
      blank = 1'b0;
      tag++;
      push_out(n + 1, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0);
      push_addr(n + 1, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    hcount = 11'd3;
    vcount = 10'd0;
    hsync = 1'b1;
    vsync = 1'b1;
    blank = 1'b0;
    tag++;
    for (int k = 1; k < L; k++)
      push_out(n + k, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0);
    push_out(n + L, 12'hFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    push_addr(n + 1, 0);
    pxl(4, 0, 12'h000);
    pxl(3, 0, 12'hFFF);

    // frame done pulses
    pxl(1023, 767, 12'h000);
    pxl(1022, 767, 12'h000);
    pxl(1023, 766, 12'h000);
    pxl(0, 0, 12'h000);
    drive(1023, 767, 1, 1, 0, 12'h000, 1, 1, 4080);
    pxl(10, 10, 12'h000);
    idle(8);

    checks++;
    if (q.size() != 0 || aq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0",
               q.size(), aq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
